counter_readout: RTL and testbench

Consumer end of the dual-latch timestamp counter's readout handshake. It watches the two "data latched" ready flags and captures the corresponding 64-bit count and 26-bit phase words. It serializes each capture as a 13-byte record onto a byte-wide valid/ready stream feeding the USB FIFO. When a record has been fully accepted, it pulses the matching latch-reset so the counter can latch again.

---
 rtl/counter_readout_pkg.sv | 28 ++
 rtl/counter_rdy_sync.sv | 31 +++
 rtl/counter_readout.sv | 185 ++++++++++++++++++
 tb/tb_counter_readout.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_readout_pkg.sv
// counter_readout_pkg
// Shared types and constants for the timestamp counter readout block.
//   state_t          readout FSM states
//   RECORD_BYTES     bytes per serialized record (header + 12 payload bytes)
//   LAST_BYTE_IDX    byte index of the final record byte
//   HDR_BASE_DEFAULT default upper nibble of the header byte
//   CH1_ID / CH2_ID  channel id field placed in the header byte
package counter_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SEND,
    ST_ACK
  } state_t;

  localparam int         RECORD_BYTES     = 13;
  localparam logic [3:0] LAST_BYTE_IDX    = 4'(RECORD_BYTES - 1);
  localparam logic [3:0] HDR_BASE_DEFAULT = 4'hA;
  localparam logic [1:0] CH1_ID           = 2'b01;
  localparam logic [1:0] CH2_ID           = 2'b10;

  // Header byte: base nibble, two zero bits, then the one-hot channel id.
  function automatic logic [7:0] make_header(input logic [3:0] base, input logic [1:0] ch);
    return {base, 2'b00, ch};
  endfunction

endpackage

// File: rtl/counter_rdy_sync.sv
// counter_rdy_sync
// Multi-flop synchronizer for a single asynchronous level signal.
//   clk       destination clock
//   reset     synchronous active-high reset, clears the chain
//   async_in  level from another clock domain
//   sync_out  synchronized level, STAGES cycles behind async_in
// STAGES must be at least 2.
module counter_rdy_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous level through the flop chain; the first flop may
  // go metastable, the later ones give it time to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/counter_readout.sv
// counter_readout
// Consumer side of the dual-latch timestamp counter readout handshake.
// Watches both "data latched" flags, captures the latched 64-bit count and
// phase word of the chosen channel, streams it as a 13-byte record on a
// byte-wide valid/ready interface and then pulses that channel's latch reset.
//   globalClock                  clock, all logic on posedge
//   iReset                       synchronous active-high reset
//   iRdyCOUNTER / iRdyCOUNTER2   channel data-latched flags (asynchronous)
//   i1COUNTER/Hi/Phase           channel 1 latched low, high and phase words
//   i2COUNTER/Hi/Phase           channel 2 latched low, high and phase words
//   oResetLatch1 / oResetLatch2  one-cycle acknowledge per channel
//   oByte / oByteValid           stream data and valid (registered)
//   iByteReady                   stream ready from the USB FIFO
//   oBusy                        high whenever the FSM is not idle
//   oRecordCount                 completed record count, wraps at 16 bits
module counter_readout
  import counter_readout_pkg::*;
#(
  parameter logic [3:0] pHDR_BASE    = HDR_BASE_DEFAULT,
  parameter int         pSYNC_STAGES = 2
) (
  input  logic        globalClock,
  input  logic        iReset,
  input  logic        iRdyCOUNTER,
  input  logic        iRdyCOUNTER2,
  input  logic [31:0] i1COUNTER,
  input  logic [31:0] i1COUNTERHi,
  input  logic [31:0] i1COUNTERPhase,
  input  logic [31:0] i2COUNTER,
  input  logic [31:0] i2COUNTERHi,
  input  logic [31:0] i2COUNTERPhase,
  output logic        oResetLatch1,
  output logic        oResetLatch2,
  output logic [7:0]  oByte,
  output logic        oByteValid,
  input  logic        iByteReady,
  output logic        oBusy,
  output logic [15:0] oRecordCount
);

  state_t         state;
  state_t         next_state;
  logic           rdy1_sync;
  logic           rdy2_sync;
  logic           blk1;
  logic           blk2;
  logic           armed1;
  logic           armed2;
  logic           last_ch2;
  logic           sel_ch2;
  logic           pick_ch2;
  logic [103:0]   shift_reg;
  logic [3:0]     byte_idx;
  logic           byte_valid;
  logic [15:0]    record_count;

  counter_rdy_sync #(.STAGES(pSYNC_STAGES)) u_sync1 (
    .clk      (globalClock),
    .reset    (iReset),
    .async_in (iRdyCOUNTER),
    .sync_out (rdy1_sync)
  );

  counter_rdy_sync #(.STAGES(pSYNC_STAGES)) u_sync2 (
    .clk      (globalClock),
    .reset    (iReset),
    .async_in (iRdyCOUNTER2),
    .sync_out (rdy2_sync)
  );

  // A channel is only eligible once its previous acknowledge has been seen
  // to take effect (synced ready went low), otherwise we would re-read the
  // same latched value while the counter's reset is still in flight.
  assign armed1 = rdy1_sync & ~blk1;
  assign armed2 = rdy2_sync & ~blk2;

  // State register.
  always_ff @(posedge globalClock) begin
    if (iReset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and round-robin pick. On a tie the channel that was
  // not served last wins; alone, an armed channel always wins.
  always_comb begin
    next_state = state;
    pick_ch2   = 1'b0;
    case (state)
      ST_IDLE: begin
        pick_ch2 = armed2 & (~armed1 | ~last_ch2);
        if (armed1 | armed2) begin
          next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        next_state = ST_SEND;
      end
      ST_SEND: begin
        if (byte_valid && iByteReady && (byte_idx == LAST_BYTE_IDX)) begin
          next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: arbitration pointer, record shift register, byte counter,
  // block bits and record counter. The header sits in the low byte of the
  // shift register so the stream is simply the register's bottom byte and
  // each accepted byte shifts the next one down.
  always_ff @(posedge globalClock) begin
    if (iReset) begin
      blk1         <= 1'b0;
      blk2         <= 1'b0;
      last_ch2     <= 1'b1;
      sel_ch2      <= 1'b0;
      shift_reg    <= '0;
      byte_idx     <= '0;
      byte_valid   <= 1'b0;
      record_count <= '0;
    end else begin
      if (!rdy1_sync) begin
        blk1 <= 1'b0;
      end
      if (!rdy2_sync) begin
        blk2 <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (armed1 | armed2) begin
            sel_ch2  <= pick_ch2;
            last_ch2 <= pick_ch2;
          end
        end
        ST_CAPTURE: begin
          if (sel_ch2) begin
            shift_reg <= {i2COUNTERPhase, i2COUNTERHi, i2COUNTER,
                          make_header(pHDR_BASE, CH2_ID)};
          end else begin
            shift_reg <= {i1COUNTERPhase, i1COUNTERHi, i1COUNTER,
                          make_header(pHDR_BASE, CH1_ID)};
          end
          byte_idx   <= '0;
          byte_valid <= 1'b1;
        end
        ST_SEND: begin
          if (byte_valid && iByteReady) begin
            shift_reg <= shift_reg >> 8;
            byte_idx  <= byte_idx + 4'd1;
            if (byte_idx == LAST_BYTE_IDX) begin
              byte_valid <= 1'b0;
            end
          end
        end
        ST_ACK: begin
          record_count <= record_count + 16'd1;
          if (sel_ch2) begin
            blk2 <= 1'b1;
          end else begin
            blk1 <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign oByte        = shift_reg[7:0];
  assign oByteValid   = byte_valid;
  assign oResetLatch1 = (state == ST_ACK) & ~sel_ch2;
  assign oResetLatch2 = (state == ST_ACK) &  sel_ch2;
  assign oBusy        = (state != ST_IDLE);
  assign oRecordCount = record_count;

endmodule

// File: tb/tb_counter_readout.sv
// tb_counter_readout
// Self-checking bench for counter_readout. Records are predicted from the
// channel words with plain arithmetic and compared byte by byte.
module tb_counter_readout;

  localparam logic [3:0] HDR = 4'hA;
  localparam int SYNC = 2;

  logic        globalClock = 1'b0;
  logic        iReset;
  logic        iRdyCOUNTER;
  logic        iRdyCOUNTER2;
  logic [31:0] i1COUNTER, i1COUNTERHi, i1COUNTERPhase;
  logic [31:0] i2COUNTER, i2COUNTERHi, i2COUNTERPhase;
  logic        oResetLatch1, oResetLatch2;
  logic [7:0]  oByte;
  logic        oByteValid;
  logic        iByteReady;
  logic        oBusy;
  logic [15:0] oRecordCount;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_count = 16'd0;

  counter_readout #(.pHDR_BASE(HDR), .pSYNC_STAGES(SYNC)) dut (
    .globalClock    (globalClock),
    .iReset         (iReset),
    .iRdyCOUNTER    (iRdyCOUNTER),
    .iRdyCOUNTER2   (iRdyCOUNTER2),
    .i1COUNTER      (i1COUNTER),
    .i1COUNTERHi    (i1COUNTERHi),
    .i1COUNTERPhase (i1COUNTERPhase),
    .i2COUNTER      (i2COUNTER),
    .i2COUNTERHi    (i2COUNTERHi),
    .i2COUNTERPhase (i2COUNTERPhase),
    .oResetLatch1   (oResetLatch1),
    .oResetLatch2   (oResetLatch2),
    .oByte          (oByte),
    .oByteValid     (oByteValid),
    .iByteReady     (iByteReady),
    .oBusy          (oBusy),
    .oRecordCount   (oRecordCount)
  );

  always #5 globalClock = ~globalClock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected record byte: header, then lo, hi, phase words little-endian.
  function automatic logic [7:0] model_byte(input logic [1:0] ch, input logic [31:0] lo,
                                            input logic [31:0] hi, input logic [31:0] ph,
                                            input int idx);
    logic [31:0] w;
    if (idx == 0) return {HDR, 2'b00, ch};
    if (idx <= 4)      w = lo;
    else if (idx <= 8) w = hi;
    else               w = ph;
    return 8'((w >> (8 * ((idx - 1) % 4))) & 32'hFF);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge globalClock);
  endtask

  task automatic load_channel(input logic [1:0] ch, input logic [31:0] lo,
                              input logic [31:0] hi, input logic [31:0] ph);
    if (ch == 2'd1) begin
      i1COUNTER = lo; i1COUNTERHi = hi; i1COUNTERPhase = ph;
    end else begin
      i2COUNTER = lo; i2COUNTERHi = hi; i2COUNTERPhase = ph;
    end
  endtask

  task automatic set_ready(input logic [1:0] ch, input logic v);
    if (ch == 2'd1) iRdyCOUNTER = v;
    else            iRdyCOUNTER2 = v;
  endtask

  task automatic do_reset();
    @(negedge globalClock);
    iReset = 1'b1;
    idle(2);
    iReset = 1'b0;
    exp_count = 16'd0;
  endtask

  // Collects one record, checking each byte against the model, byte hold
  // under stall, the acknowledge pulse and the record count.
  task automatic receive_record(input logic [1:0] ch, input logic [31:0] lo,
                                input logic [31:0] hi, input logic [31:0] ph,
                                input bit stall, input string tag,
                                output int first_valid_cyc);
    int got = 0;
    int cyc = 0;
    int early_ack = 0;
    bit holding = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp;
    first_valid_cyc = -1;
    while (got < 13 && cyc < 300) begin
      @(negedge globalClock);
      cyc++;
      iByteReady = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
      if (oResetLatch1 || oResetLatch2) early_ack++;
      if (oByteValid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (holding) begin
          tests_run++;
          if (oByte !== held) begin
            tests_failed++;
            $display("[TB] FAIL %s hold: got %h expected %h", tag, oByte, held);
          end
        end
        if (iByteReady) begin
          exp = model_byte(ch, lo, hi, ph, got);
          tests_run++;
          if (oByte !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s byte%0d: got %h expected %h", tag, got, oByte, exp);
          end
          got++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held = oByte;
        end
      end
    end
    tests_run++;
    if (got != 13) begin
      tests_failed++;
      $display("[TB] FAIL %s bytes: got %0d expected 13 (timeout)", tag, got);
    end
    tests_run++;
    if (early_ack != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s early_ack: got %0d pulses expected 0", tag, early_ack);
    end
    if (got == 13) begin
      @(negedge globalClock);
      tests_run++;
      if ({oResetLatch1, oResetLatch2, oByteValid} !== {ch == 2'd1, ch == 2'd2, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL %s ack: got l1=%b l2=%b v=%b expected l1=%b l2=%b v=0",
                 tag, oResetLatch1, oResetLatch2, oByteValid, ch == 2'd1, ch == 2'd2);
      end
      @(negedge globalClock);
      exp_count = exp_count + 16'd1;
      tests_run++;
      if ({oResetLatch1, oResetLatch2} !== 2'b00 || oRecordCount !== exp_count) begin
        tests_failed++;
        $display("[TB] FAIL %s post_ack: got l1=%b l2=%b count=%h expected 0 0 %h",
                 tag, oResetLatch1, oResetLatch2, oRecordCount, exp_count);
      end
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    iRdyCOUNTER = 1'b0; iRdyCOUNTER2 = 1'b0; iByteReady = 1'b0;
    load_channel(2'd1, 32'd0, 32'd0, 32'd0);
    load_channel(2'd2, 32'd0, 32'd0, 32'd0);
    idle(3);
    tests_run++;
    if ({oByteValid, oResetLatch1, oResetLatch2, oBusy} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got v=%b l1=%b l2=%b busy=%b expected all 0",
               oByteValid, oResetLatch1, oResetLatch2, oBusy);
    end
    tests_run++;
    if (oByte !== 8'h00 || oRecordCount !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got byte=%h count=%h expected 00 0000", oByte, oRecordCount);
    end
    iReset = 1'b0;
    exp_count = 16'd0;
    idle(2);
  endtask

  task automatic test_single_ch1();
    int fv;
    load_channel(2'd1, 32'h11223344, 32'h55667788, 32'h000155AA);
    iRdyCOUNTER = 1'b1;
    receive_record(2'd1, 32'h11223344, 32'h55667788, 32'h000155AA, 1'b0, "single", fv);
    tests_run++;
    if (fv != SYNC + 2) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: got %0d expected %0d", fv, SYNC + 2);
    end
    iRdyCOUNTER = 1'b0;
    idle(5);
  endtask

  task automatic test_backpressure_ch2();
    int fv;
    logic [31:0] lo = $urandom, hi = $urandom, ph = $urandom & 32'h03FF_FFFF;
    load_channel(2'd2, lo, hi, ph);
    iRdyCOUNTER2 = 1'b1;
    receive_record(2'd2, lo, hi, ph, 1'b1, "backpressure", fv);
    iRdyCOUNTER2 = 1'b0;
    idle(5);
  endtask

  task automatic test_simultaneous();
    int fv;
    logic [31:0] lo1 = $urandom, hi1 = $urandom, ph1 = $urandom & 32'h03FF_FFFF;
    logic [31:0] lo2 = $urandom, hi2 = $urandom, ph2 = $urandom & 32'h03FF_FFFF;
    do_reset();
    load_channel(2'd1, lo1, hi1, ph1);
    load_channel(2'd2, lo2, hi2, ph2);
    iRdyCOUNTER = 1'b1;
    iRdyCOUNTER2 = 1'b1;
    receive_record(2'd1, lo1, hi1, ph1, 1'b0, "simul_ch1", fv);
    iRdyCOUNTER = 1'b0;
    receive_record(2'd2, lo2, hi2, ph2, 1'b0, "simul_ch2", fv);
    iRdyCOUNTER2 = 1'b0;
    tests_run++;
    if (oRecordCount !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL simul_count: got %0d expected 2", oRecordCount);
    end
    idle(5);
  endtask

  task automatic test_ready_held();
    int fv;
    int stray = 0;
    logic [31:0] lo = $urandom, hi = $urandom, ph = $urandom & 32'h03FF_FFFF;
    load_channel(2'd1, lo, hi, ph);
    iRdyCOUNTER = 1'b1;
    receive_record(2'd1, lo, hi, ph, 1'b0, "held_first", fv);
    repeat (50) begin
      @(negedge globalClock);
      if (oByteValid || oBusy) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("[TB] FAIL held_no_reread: got %0d active cycles expected 0", stray);
    end
    iRdyCOUNTER = 1'b0;
    idle(5);
    lo = $urandom; hi = $urandom; ph = $urandom & 32'h03FF_FFFF;
    load_channel(2'd1, lo, hi, ph);
    iRdyCOUNTER = 1'b1;
    receive_record(2'd1, lo, hi, ph, 1'b0, "held_second", fv);
    stray = 0;
    repeat (20) begin
      @(negedge globalClock);
      if (oByteValid || oBusy) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("[TB] FAIL held_single_new: got %0d active cycles expected 0", stray);
    end
    iRdyCOUNTER = 1'b0;
    idle(5);
  endtask

  task automatic test_reset_mid();
    int fv;
    int got = 0;
    int cyc = 0;
    logic [31:0] lo = $urandom, hi = $urandom, ph = $urandom & 32'h03FF_FFFF;
    do_reset();
    load_channel(2'd1, lo, hi, ph);
    iRdyCOUNTER = 1'b1;
    iByteReady = 1'b1;
    while (got < 6 && cyc < 100) begin
      @(negedge globalClock);
      cyc++;
      if (oByteValid) got++;
    end
    @(negedge globalClock);
    tests_run++;
    if (!oByteValid || oByte !== model_byte(2'd1, lo, hi, ph, 6)) begin
      tests_failed++;
      $display("[TB] FAIL midreset_byte6: got v=%b %h expected v=1 %h",
               oByteValid, oByte, model_byte(2'd1, lo, hi, ph, 6));
    end
    iReset = 1'b1;
    @(negedge globalClock);
    tests_run++;
    if ({oByteValid, oResetLatch1, oResetLatch2} !== 3'b000 || oRecordCount !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_drop: got v=%b l1=%b l2=%b count=%h expected 0 0 0 0000",
               oByteValid, oResetLatch1, oResetLatch2, oRecordCount);
    end
    @(negedge globalClock);
    iReset = 1'b0;
    exp_count = 16'd0;
    receive_record(2'd1, lo, hi, ph, 1'b0, "midreset_resend", fv);
    iRdyCOUNTER = 1'b0;
    idle(5);
  endtask

  task automatic test_random_mix();
    int fv;
    logic [1:0] ch;
    logic [31:0] lo, hi, ph;
    bit stall;
    for (int i = 0; i < 6; i++) begin
      ch = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
      lo = $urandom; hi = $urandom; ph = $urandom & 32'h03FF_FFFF;
      stall = 1'($urandom_range(0, 1));
      load_channel(ch, lo, hi, ph);
      set_ready(ch, 1'b1);
      receive_record(ch, lo, hi, ph, stall, $sformatf("mix%0d", i), fv);
      set_ready(ch, 1'b0);
      idle(4);
    end
  endtask

  task automatic test_wrap();
    int fv;
    logic [31:0] lo = $urandom, hi = $urandom, ph = $urandom & 32'h03FF_FFFF;
    @(negedge globalClock);
    force dut.record_count = 16'hFFFF;
    @(negedge globalClock);
    release dut.record_count;
    exp_count = 16'hFFFF;
    @(negedge globalClock);
    tests_run++;
    if (oRecordCount !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL wrap_preload: got %h expected ffff", oRecordCount);
    end
    load_channel(2'd2, lo, hi, ph);
    iRdyCOUNTER2 = 1'b1;
    receive_record(2'd2, lo, hi, ph, 1'b0, "wrap", fv);
    tests_run++;
    if (oRecordCount !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL wrap_count: got %h expected 0000", oRecordCount);
    end
    iRdyCOUNTER2 = 1'b0;
    idle(5);
  endtask

  initial begin
    test_reset();
    test_single_ch1();
    test_backpressure_ch2();
    test_simultaneous();
    test_ready_held();
    test_reset_mid();
    test_random_mix();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
